// File: rtl/ibex_pkg.sv
// Ibex-wide type definitions used by the register-file scrubber.
package ibex_pkg;

    typedef enum logic [2:0] {
        SCRUB_IDLE,
        SCRUB_WAIT,
        SCRUB_READ,
        SCRUB_CHECK,
        SCRUB_WRITE
    } scrub_state_e;

endpackage

// File: rtl/prim_secded_pkg.sv
// Shared constants for the inverted Hsiao (39,32) SEC-DED code: widths,
// per-check-bit parity masks and the inversion pattern.
package prim_secded_pkg;

    localparam int unsigned Secded3932DataW  = 32;
    localparam int unsigned Secded3932CodeW  = 39;
    localparam int unsigned Secded3932CheckW = Secded3932CodeW - Secded3932DataW;

    // Row k selects the data bits covered by check bit 32+k.
    localparam logic [38:0] SecdedInv3932Mask [7] = '{
        39'h002606BD25,
        39'h00DEBA8050,
        39'h00413D89AA,
        39'h0031234ED1,
        39'h00C2C1323B,
        39'h002DCC624C,
        39'h0098505586
    };

    // Inverting some check bits keeps all-zero and all-one words invalid.
    localparam logic [38:0] SecdedInv3932Inv = 39'h2A00000000;

endpackage

// File: rtl/prim_secded_inv_39_32_dec.sv
// Inverted Hsiao (39,32) decoder: corrects any single-bit error in the data
// field and flags single (err_o[0]) or double (err_o[1]) errors.
module prim_secded_inv_39_32_dec
    import prim_secded_pkg::*;
(
    input  logic [Secded3932CodeW-1:0] data_i,
    output logic [Secded3932DataW-1:0] data_o,
    output logic [1:0]                 err_o
);

    logic [Secded3932CodeW-1:0]  raw;
    logic [Secded3932CheckW-1:0] syn;
    logic [Secded3932CheckW-1:0] col;

    assign raw = data_i ^ SecdedInv3932Inv;

    always_comb begin
        syn = '0;
        for (int k = 0; k < 7; k++) begin
            syn[k] = ^(raw & (SecdedInv3932Mask[k] | (39'd1 << (32 + k))));
        end
        // A data bit is flipped when the syndrome equals that bit's mask column.
        data_o = raw[31:0];
        col    = '0;
        for (int j = 0; j < 32; j++) begin
            for (int k = 0; k < 7; k++) begin
                col[k] = SecdedInv3932Mask[k][j];
            end
            data_o[j] = raw[j] ^ (syn == col);
        end
        err_o[0] = ^syn;
        err_o[1] = ~err_o[0] & (|syn);
    end

endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted Hsiao (39,32) encoder: appends seven check bits, then applies
// the inversion pattern.
module prim_secded_inv_39_32_enc
    import prim_secded_pkg::*;
(
    input  logic [Secded3932DataW-1:0] data_i,
    output logic [Secded3932CodeW-1:0] data_o
);

    logic [Secded3932CodeW-1:0] plain;

    assign plain = {{Secded3932CheckW{1'b0}}, data_i};

    always_comb begin
        data_o = plain;
        for (int k = 0; k < 7; k++) begin
            data_o[32+k] = ^(plain & SecdedInv3932Mask[k]);
        end
        data_o = data_o ^ SecdedInv3932Inv;
    end

endmodule

// File: rtl/ibex_rf_scrubber.sv
// Background scrubber for the ECC-protected Ibex register file: periodically
// reads each register over port B, corrects single-bit errors in place and
// raises a sticky alert on uncorrectable ones.
module ibex_rf_scrubber
    import ibex_pkg::*;
    import prim_secded_pkg::*;
#(
    parameter bit          RV32E         = 1'b0,
    parameter logic [15:0] ScrubInterval = 16'd256
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       scrub_en_i,
    input  logic                       core_rd_idle_i,
    input  logic                       core_we_i,
    input  logic [4:0]                 core_waddr_i,
    output logic                       scrub_re_o,
    output logic [4:0]                 scrub_raddr_o,
    input  logic [Secded3932CodeW-1:0] scrub_rdata_i,
    output logic                       scrub_we_o,
    output logic [4:0]                 scrub_waddr_o,
    output logic [Secded3932CodeW-1:0] scrub_wdata_o,
    output logic                       err_corr_o,
    output logic                       alert_major_o,
    output logic                       sweep_done_o
);

    localparam logic [4:0]   LastAddr = RV32E ? 5'd15 : 5'd31;
    localparam scrub_state_e StepNext = (ScrubInterval == 16'd0) ? SCRUB_READ : SCRUB_WAIT;

    scrub_state_e               state_q;
    logic [4:0]                 addr_q;
    logic [15:0]                cnt_q;
    logic [Secded3932CodeW-1:0] word_q;
    logic                       cancel_q;
    logic                       alert_q;

    logic [Secded3932DataW-1:0] dec_data;
    logic [1:0]                 dec_err;
    logic                       hazard;
    logic                       step_done;
    logic [4:0]                 addr_inc;

    prim_secded_inv_39_32_dec u_dec (
        .data_i (word_q),
        .data_o (dec_data),
        .err_o  (dec_err)
    );

    prim_secded_inv_39_32_enc u_enc (
        .data_i (dec_data),
        .data_o (scrub_wdata_o)
    );

    assign hazard   = core_we_i && (core_waddr_i == addr_q);
    assign addr_inc = (addr_q == LastAddr) ? 5'd1 : addr_q + 5'd1;

    // A step finishes in CHECK unless a write-back is still owed, and in WRITE
    // once the write port is free or the core has overwritten the register.
    assign step_done = ((state_q == SCRUB_CHECK) && (!dec_err[0] || cancel_q || hazard)) ||
                       ((state_q == SCRUB_WRITE) && (!core_we_i || hazard));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= SCRUB_IDLE;
            addr_q   <= 5'd1;
            cnt_q    <= '0;
            word_q   <= '0;
            cancel_q <= 1'b0;
            alert_q  <= 1'b0;
        end else begin
            if ((state_q == SCRUB_CHECK) && dec_err[1]) begin
                alert_q <= 1'b1;
            end
            if (!scrub_en_i) begin
                state_q  <= SCRUB_IDLE;
                cancel_q <= 1'b0;
            end else if (step_done) begin
                addr_q   <= addr_inc;
                cnt_q    <= ScrubInterval;
                state_q  <= StepNext;
                cancel_q <= 1'b0;
            end else begin
                unique case (state_q)
                    SCRUB_IDLE: begin
                        cnt_q   <= ScrubInterval;
                        state_q <= StepNext;
                    end
                    SCRUB_WAIT: begin
                        if (cnt_q <= 16'd1) begin
                            cnt_q   <= '0;
                            state_q <= SCRUB_READ;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    SCRUB_READ: begin
                        if (core_rd_idle_i) begin
                            word_q   <= scrub_rdata_i;
                            cancel_q <= hazard;
                            state_q  <= SCRUB_CHECK;
                        end
                    end
                    SCRUB_CHECK: state_q <= SCRUB_WRITE;
                    SCRUB_WRITE: begin
                    end
                    default: state_q <= SCRUB_IDLE;
                endcase
            end
        end
    end

    // Port strobes depend on same-cycle arbitration inputs, so they stay combinational.
    assign scrub_re_o    = scrub_en_i && (state_q == SCRUB_READ) && core_rd_idle_i;
    assign scrub_we_o    = scrub_en_i && (state_q == SCRUB_WRITE) && !core_we_i;
    assign scrub_raddr_o = addr_q;
    assign scrub_waddr_o = addr_q;
    assign err_corr_o    = (state_q == SCRUB_CHECK) && dec_err[0];
    assign sweep_done_o  = (state_q == SCRUB_CHECK) && (addr_q == LastAddr);
    assign alert_major_o = alert_q;

endmodule
